// File: rtl/arbiter_stream_mux_pkg.sv
// arbiter_stream_mux_pkg
// Shared definitions for the arbiter stream mux:
//   - mux_state_e : lock FSM encodings (IDLE=0, LOCK=1, RELEASE=2)
//   - sel2onehot  : binary select -> one-hot mask (up to ONEHOT_MAX ports)
`ifndef ARBITER_STREAM_MUX_PKG_SV
`define ARBITER_STREAM_MUX_PKG_SV

package arbiter_stream_mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK    = 2'd1,
    RELEASE = 2'd2
  } mux_state_e;

  localparam int ONEHOT_MAX = 64;

  // Callers cast the result down to their own port count.
  function automatic logic [ONEHOT_MAX-1:0] sel2onehot(input logic [7:0] sel);
    return {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

`endif

// File: rtl/arbiter_stream_mux_if.sv
// arbiter_stream_mux_if
// Bundles every handshake/bus signal of the stream mux.
//   up_*   : per-port upstream streams (data packed port-major)
//   arb_*  : request out to / grant, select, active in from the arbiter
//   dn_*   : single muxed downstream stream
//   owner/busy : lock status
// Modports: master = the mux, slave = sources, arbiter and sink around it.
interface arbiter_stream_mux_if #(
  parameter int NUM_PORTS  = 6,
  parameter int SEL_WIDTH  = $clog2(NUM_PORTS),
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] up_data;
  logic [NUM_PORTS-1:0]            up_valid;
  logic [NUM_PORTS-1:0]            up_last;
  logic [NUM_PORTS-1:0]            up_ready;
  logic [NUM_PORTS-1:0]            arb_request;
  logic [NUM_PORTS-1:0]            arb_grant;
  logic [SEL_WIDTH-1:0]            arb_select;
  logic                            arb_active;
  logic [DATA_WIDTH-1:0]           dn_data;
  logic                            dn_valid;
  logic                            dn_last;
  logic                            dn_ready;
  logic [SEL_WIDTH-1:0]            owner;
  logic                            busy;

  modport master (
    input  up_data, up_valid, up_last,
    output up_ready,
    output arb_request,
    input  arb_grant, arb_select, arb_active,
    output dn_data, dn_valid, dn_last,
    input  dn_ready,
    output owner, busy
  );

  modport slave (
    output up_data, up_valid, up_last,
    input  up_ready,
    input  arb_request,
    output arb_grant, arb_select, arb_active,
    input  dn_data, dn_valid, dn_last,
    output dn_ready,
    input  owner, busy
  );
endinterface

// File: rtl/arbiter_stream_mux_stream_out_reg.sv
// stream_out_reg
// One-deep valid/ready register slice. Full throughput: a new word is
// accepted in the same cycle the held word drains.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/in_valid    : write side, in_ready = ~out_valid | out_ready
//   out_data/out_valid  : registered read side, held while out_ready=0
module stream_out_reg #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;

  assign in_ready = ~vld_p1 | out_ready;

  // stage p1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (in_valid && in_ready) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;

endmodule

// File: rtl/arbiter_stream_mux.sv
// arbiter_stream_mux
// Consumer stage behind a registered round-robin arbiter. Forwards port
// valids as requests, locks the granted port for a whole packet, muxes it
// onto one registered downstream stream and then hands the token back.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : arbiter_stream_mux_if.master (up_*, arb_*, dn_*, owner, busy)
// Optional build macro ARB_MUX_BURST_LIMIT_EN: forces a release after
// MAX_BEATS accepted beats without last; the packet resumes at its next grant.
module arbiter_stream_mux
  import arbiter_stream_mux_pkg::*;
#(
  parameter int NUM_PORTS  = 6,
  parameter int SEL_WIDTH  = $clog2(NUM_PORTS),
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  arbiter_stream_mux_if.master  bus
);

  if (MAX_BEATS < 1 || NUM_PORTS < 2 || NUM_PORTS > ONEHOT_MAX) begin : g_param_err
    $error("arbiter_stream_mux: unsupported NUM_PORTS/MAX_BEATS");
  end

  mux_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0] owner_q;
  logic                 after_rel_q;
  logic [NUM_PORTS-1:0] owner_oh;
  logic                 own_valid, own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                 in_valid, in_ready, accept;
  logic                 grant_ok, limit_hit;
  logic [DATA_WIDTH:0]  dn_word;

  assign owner_oh = NUM_PORTS'(sel2onehot(8'(owner_q)));

  // Owner's stream, selected through the one-hot mask so an out-of-range
  // select simply yields an idle stream.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (owner_oh[i]) begin
        own_valid = bus.up_valid[i];
        own_last  = bus.up_last[i];
        own_data  = bus.up_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_valid = (state_q == LOCK) && own_valid;
  assign accept   = in_valid && in_ready;

  // The grant seen in the first IDLE cycle after RELEASE was computed from
  // the RELEASE request, so it is skipped.
  assign grant_ok = (state_q == IDLE) && bus.arb_active && !after_rel_q;

`ifdef ARB_MUX_BURST_LIMIT_EN
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  logic [BEAT_W-1:0] beat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (grant_ok) begin
      beat_cnt_q <= '0;
    end else if (accept) begin
      beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
    end
  end

  assign limit_hit = (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    bus.arb_request = bus.up_valid;
    bus.up_ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_ok) state_d = LOCK;
      end
      LOCK: begin
        bus.arb_request = owner_oh & bus.up_valid;
        bus.up_ready    = owner_oh & {NUM_PORTS{in_ready}};
        if (accept && (own_last || limit_hit)) state_d = RELEASE;
      end
      RELEASE: begin
        bus.arb_request = bus.up_valid & ~owner_oh;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      after_rel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      after_rel_q <= (state_q == RELEASE);
      if (grant_ok) owner_q <= bus.arb_select;
    end
  end

  stream_out_reg #(.WIDTH(DATA_WIDTH + 1)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({own_last, own_data}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (dn_word),
    .out_valid (bus.dn_valid),
    .out_ready (bus.dn_ready)
  );

  assign bus.dn_last = dn_word[DATA_WIDTH];
  assign bus.dn_data = dn_word[DATA_WIDTH-1:0];
  assign bus.owner   = owner_q;
  assign bus.busy    = (state_q != IDLE);

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    grant_ok |-> ($onehot(bus.arb_grant) &&
                  bus.arb_grant == NUM_PORTS'(sel2onehot(8'(bus.arb_select)))));
`endif

endmodule

// File: tb/tb_arbiter_stream_mux.sv
module tb_arbiter_stream_mux;

  localparam int NP = 6;
  localparam int DW = 32;

  typedef struct packed {
    logic          gap;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  beat_t          src_q [NP][$];
  logic           rdy_pat[$];
  logic [DW:0]    rx[$];

  arbiter_stream_mux_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

  arbiter_stream_mux #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered arbiter stand-in: keeps its grant while the current holder
  // requests, otherwise moves to the next requester after it.
  logic [2:0] arb_sel;
  logic       arb_act;
  logic [2:0] pick;
  int         idx;

  always_comb begin
    pick = arb_sel;
    idx  = 0;
    for (int k = NP - 1; k >= 0; k--) begin
      idx = (int'(arb_sel) + k) % NP;
      if (bus.arb_request[idx]) pick = 3'(idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_act <= 1'b0;
      arb_sel <= '0;
    end else if (|bus.arb_request) begin
      arb_act <= 1'b1;
      arb_sel <= pick;
    end else begin
      arb_act <= 1'b0;
    end
  end

  assign bus.arb_select = arb_sel;
  assign bus.arb_active = arb_act;
  assign bus.arb_grant  = arb_act ? (NP'(1) << arb_sel) : '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag, input int i, input logic last, input logic [DW-1:0] data);
    logic [63:0] obs;
    obs = (i < rx.size()) ? 64'(rx[i]) : '1;
    check($sformatf("%s[%0d]", tag, i), obs, 64'({last, data}));
  endtask

  task automatic push(input int p, input logic gap, input logic last, input logic [DW-1:0] data);
    beat_t b;
    b.gap  = gap;
    b.last = last;
    b.data = data;
    src_q[p].push_back(b);
  endtask

  // Present each port's queue head for the current cycle.
  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.up_valid[p] = 1'b0;
      bus.up_last[p]  = 1'b0;
      bus.up_data[p*DW +: DW] = '0;
      if (src_q[p].size() > 0) begin
        if (src_q[p][0].gap) begin
          void'(src_q[p].pop_front());
        end else begin
          bus.up_valid[p] = 1'b1;
          bus.up_last[p]  = src_q[p][0].last;
          bus.up_data[p*DW +: DW] = src_q[p][0].data;
        end
      end
    end
    bus.dn_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
  endtask

  task automatic tick();
    logic [NP-1:0] take;
    take = bus.up_valid & bus.up_ready;
    if (bus.dn_valid && bus.dn_ready) rx.push_back({bus.dn_last, bus.dn_data});
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (take[p]) void'(src_q[p].pop_front());
    end
    drive();
    #1;
  endtask

  task automatic run_until(input int n_rx, input int budget, output int used);
    used = 0;
    while (rx.size() < n_rx && used < budget) begin
      tick();
      used++;
    end
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.up_data  = '0;
    bus.up_valid = '0;
    bus.up_last  = '0;
    bus.dn_ready = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_dn_valid", 64'(bus.dn_valid), 64'd0);
    check("rst_dn_last",  64'(bus.dn_last),  64'd0);
    check("rst_dn_data",  64'(bus.dn_data),  64'd0);
    check("rst_busy",     64'(bus.busy),     64'd0);
    check("rst_owner",    64'(bus.owner),    64'd0);
    check("rst_up_ready", 64'(bus.up_ready), 64'd0);
    rst_n = 1'b1;
    drive();
    #1;
    repeat (2) tick();

    // single packet from port 2
    rx.delete();
    push(2, 0, 0, 32'h2000_0000);
    push(2, 0, 0, 32'h2000_0001);
    push(2, 0, 1, 32'h2000_0002);
    drive();
    #1;
    tick();
    check("sp_c1_up_ready", 64'(bus.up_ready), 64'd0);
    tick();
    check("sp_c2_up_ready", 64'(bus.up_ready), 64'h04);
    check("sp_c2_owner",    64'(bus.owner),    64'd2);
    check("sp_c2_busy",     64'(bus.busy),     64'd1);
    check("sp_c2_dn_valid", 64'(bus.dn_valid), 64'd0);
    check("sp_c2_arb_req",  64'(bus.arb_request), 64'h04);
    tick();
    check("sp_c3_dn", 64'({bus.dn_valid, bus.dn_last, bus.dn_data}), {31'd0, 1'b1, 1'b0, 32'h2000_0000});
    tick();
    check("sp_c4_dn", 64'({bus.dn_valid, bus.dn_last, bus.dn_data}), {31'd0, 1'b1, 1'b0, 32'h2000_0001});
    tick();
    check("sp_c5_dn", 64'({bus.dn_valid, bus.dn_last, bus.dn_data}), {31'd0, 1'b1, 1'b1, 32'h2000_0002});
    check("sp_c5_busy",     64'(bus.busy),     64'd1);
    check("sp_c5_up_ready", 64'(bus.up_ready), 64'd0);
    tick();
    check("sp_c6_busy",     64'(bus.busy),     64'd0);
    check("sp_c6_dn_valid", 64'(bus.dn_valid), 64'd0);
    check("sp_rx_count",    64'(rx.size()),    64'd3);
    repeat (3) tick();

    // asynchronous reset in the middle of a stalled packet
    rx.delete();
    for (int b = 0; b < 6; b++) push(0, 0, (b == 5), 32'h0A00_0000 + 32'(b));
    for (int b = 0; b < 8; b++) rdy_pat.push_back(1'b0);
    drive();
    #1;
    repeat (3) tick();
    check("ar_pre_busy",     64'(bus.busy),     64'd1);
    check("ar_pre_dn_valid", 64'(bus.dn_valid), 64'd1);
    check("ar_pre_up_ready", 64'(bus.up_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_dn_valid", 64'(bus.dn_valid), 64'd0);
    check("ar_busy",     64'(bus.busy),     64'd0);
    check("ar_up_ready", 64'(bus.up_ready), 64'd0);
    check("ar_dn_data",  64'(bus.dn_data),  64'd0);
    check("ar_arb_req",  64'(bus.arb_request), 64'h01);
    for (int p = 0; p < NP; p++) src_q[p].delete();
    rdy_pat.delete();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    repeat (2) tick();

    // round robin between ports 0 and 3, two 2-beat packets each
    rx.delete();
    push(0, 0, 0, 32'h0000_00A0);
    push(0, 0, 1, 32'h0000_00A1);
    push(0, 0, 0, 32'h0000_00A2);
    push(0, 0, 1, 32'h0000_00A3);
    push(3, 0, 0, 32'h3000_00B0);
    push(3, 0, 1, 32'h3000_00B1);
    push(3, 0, 0, 32'h3000_00B2);
    push(3, 0, 1, 32'h3000_00B3);
    drive();
    #1;
    run_until(8, 60, n);
    check("rr_cycles", 64'(n), 64'd20);
    check_rx("rr", 0, 1'b0, 32'h0000_00A0);
    check_rx("rr", 1, 1'b1, 32'h0000_00A1);
    check_rx("rr", 2, 1'b0, 32'h3000_00B0);
    check_rx("rr", 3, 1'b1, 32'h3000_00B1);
    check_rx("rr", 4, 1'b0, 32'h0000_00A2);
    check_rx("rr", 5, 1'b1, 32'h0000_00A3);
    check_rx("rr", 6, 1'b0, 32'h3000_00B2);
    check_rx("rr", 7, 1'b1, 32'h3000_00B3);
    repeat (3) tick();

    // downstream backpressure on a 4-beat packet from port 1
    rx.delete();
    for (int b = 0; b < 4; b++) push(1, 0, (b == 3), 32'h1000_0000 + 32'(b));
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    drive();
    #1;
    repeat (4) tick();
    check("bp_c4_up_ready", 64'(bus.up_ready), 64'd0);
    check("bp_c4_dn", 64'({bus.dn_valid, bus.dn_data}), {31'd0, 1'b1, 32'h1000_0001});
    tick();
    check("bp_c5_up_ready", 64'(bus.up_ready), 64'd0);
    check("bp_c5_dn", 64'({bus.dn_valid, bus.dn_data}), {31'd0, 1'b1, 32'h1000_0001});
    tick();
    check("bp_c6_up_ready", 64'(bus.up_ready), 64'h02);
    run_until(4, 40, n);
    check("bp_rx_count", 64'(rx.size()), 64'd4);
    for (int b = 0; b < 4; b++) check_rx("bp", b, (b == 3), 32'h1000_0000 + 32'(b));
    repeat (3) tick();

    // owner pauses mid-packet while another port waits
    rx.delete();
    push(4, 0, 0, 32'h4000_0000);
    push(4, 0, 0, 32'h4000_0001);
    for (int g = 0; g < 5; g++) push(4, 1, 0, 32'h0);
    push(4, 0, 0, 32'h4000_0002);
    push(4, 0, 1, 32'h4000_0003);
    push(0, 0, 0, 32'h0000_0C00);
    push(0, 0, 1, 32'h0000_0C01);
    drive();
    #1;
    repeat (6) tick();
    check("op_busy",     64'(bus.busy),     64'd1);
    check("op_owner",    64'(bus.owner),    64'd4);
    check("op_up_ready", 64'(bus.up_ready), 64'h10);
    check("op_arb_req",  64'(bus.arb_request), 64'd0);
    check("op_rx_count", 64'(rx.size()),    64'd2);
    run_until(6, 60, n);
    check_rx("op", 0, 1'b0, 32'h4000_0000);
    check_rx("op", 1, 1'b0, 32'h4000_0001);
    check_rx("op", 2, 1'b0, 32'h4000_0002);
    check_rx("op", 3, 1'b1, 32'h4000_0003);
    check_rx("op", 4, 1'b0, 32'h0000_0C00);
    check_rx("op", 5, 1'b1, 32'h0000_0C01);
    repeat (3) tick();

`ifdef ARB_MUX_BURST_LIMIT_EN
    // burst limit of 4 beats splits a 6-beat packet from port 1
    rx.delete();
    for (int b = 0; b < 6; b++) push(1, 0, (b == 5), 32'h1100_0000 + 32'(b));
    push(5, 0, 0, 32'h5000_0000);
    push(5, 0, 1, 32'h5000_0001);
    drive();
    #1;
    run_until(8, 80, n);
    for (int b = 0; b < 4; b++) check_rx("bl", b, 1'b0, 32'h1100_0000 + 32'(b));
    check_rx("bl", 4, 1'b0, 32'h5000_0000);
    check_rx("bl", 5, 1'b1, 32'h5000_0001);
    check_rx("bl", 6, 1'b0, 32'h1100_0004);
    check_rx("bl", 7, 1'b1, 32'h1100_0005);
    repeat (3) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
